// File: rtl/nios_with_no_onchip_sdram_cpu_oci_dct_ctrl.sv
// ============================================================================
// Module   : nios_with_no_onchip_sdram_cpu_oci_dct_ctrl
// Purpose  : Packs 2-bit trace symbols into 15-slot words and flushes them
//            downstream on full, idle timeout or end-of-test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_with_no_onchip_sdram_cpu_oci_dct_ctrl #(
   parameter int IDLE_FLUSH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sym_valid,
   input  logic [1:0]  sym_data,
   output logic        sym_ready,
   input  logic        test_ending,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [29:0] out_word,
   output logic [3:0]  out_count,
   output logic        test_has_ended,
   output logic [7:0]  drop_count
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_FLUSH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] c_IDLE_FLUSH = 8'(IDLE_FLUSH);

   state_t      r_state;
   logic [29:0] r_buf;
   logic [3:0]  r_cnt;
   logic        r_out_valid;
   logic [29:0] r_out_word;
   logic [3:0]  r_out_count;
   logic        r_has_ended;
   logic [7:0]  r_drop;
   logic        r_end_pending;
   logic [7:0]  r_idle;
   logic        r_sym_ready;

   state_t      w_state_n;
   logic [29:0] w_buf_n;
   logic [3:0]  w_cnt_n;
   logic [29:0] w_word_n;
   logic [3:0]  w_ocnt_n;
   logic        w_end_n;
   logic [7:0]  w_idle_n;
   logic [7:0]  w_drop_n;

   logic        w_accept;
   logic [29:0] w_sym_shift;
   logic [29:0] w_fill_buf;
   logic [3:0]  w_fill_cnt;
   logic [7:0]  w_idle_inc;
   logic        w_idle_hit;

   assign w_accept    = sym_valid & r_sym_ready;
   // Upper slots are always zero, so OR-ing the new symbol in is sufficient.
   assign w_sym_shift = {28'd0, sym_data} << {r_cnt, 1'b0};
   assign w_fill_buf  = w_accept ? (r_buf | w_sym_shift) : r_buf;
   assign w_fill_cnt  = r_cnt + {3'd0, w_accept};
   assign w_idle_inc  = (r_idle == 8'hFF) ? r_idle : r_idle + 8'd1;
   assign w_idle_hit  = (c_IDLE_FLUSH != 8'd0) && !w_accept &&
                        (r_cnt != 4'd0) && (w_idle_inc == c_IDLE_FLUSH);
   assign w_drop_n    = (sym_valid && !r_sym_ready && r_drop != 8'hFF) ?
                        r_drop + 8'd1 : r_drop;

   always_comb begin
      w_state_n = r_state;
      w_buf_n   = r_buf;
      w_cnt_n   = r_cnt;
      w_word_n  = r_out_word;
      w_ocnt_n  = r_out_count;
      w_end_n   = r_end_pending;
      w_idle_n  = 8'd0;
      case (r_state)
         S_FILL: begin
            w_buf_n  = w_fill_buf;
            w_cnt_n  = w_fill_cnt;
            w_idle_n = (!w_accept && r_cnt != 4'd0) ? w_idle_inc : 8'd0;
            // A same-cycle accept is folded in before any flush decision.
            if (w_fill_cnt == 4'd15 || (test_ending && w_fill_cnt != 4'd0) || w_idle_hit) begin
               w_state_n = S_FLUSH;
               w_word_n  = w_fill_buf;
               w_ocnt_n  = w_fill_cnt;
               w_end_n   = test_ending;
               w_idle_n  = 8'd0;
            end else if (test_ending) begin
               w_state_n = S_DONE;
            end
         end
         S_FLUSH: begin
            if (test_ending) begin
               w_end_n = 1'b1;
            end
            if (out_ready) begin
               w_buf_n   = 30'd0;
               w_cnt_n   = 4'd0;
               w_end_n   = 1'b0;
               w_state_n = (r_end_pending || test_ending) ? S_DONE : S_FILL;
            end
         end
         S_DONE: begin
            w_state_n = S_DONE;
         end
         default: begin
            w_state_n = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FILL;
         r_buf         <= 30'd0;
         r_cnt         <= 4'd0;
         r_out_valid   <= 1'b0;
         r_out_word    <= 30'd0;
         r_out_count   <= 4'd0;
         r_has_ended   <= 1'b0;
         r_drop        <= 8'd0;
         r_end_pending <= 1'b0;
         r_idle        <= 8'd0;
         r_sym_ready   <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_buf         <= w_buf_n;
         r_cnt         <= w_cnt_n;
         r_out_valid   <= (w_state_n == S_FLUSH);
         r_out_word    <= w_word_n;
         r_out_count   <= w_ocnt_n;
         r_has_ended   <= (w_state_n == S_DONE);
         r_drop        <= w_drop_n;
         r_end_pending <= w_end_n;
         r_idle        <= w_idle_n;
         r_sym_ready   <= (w_state_n == S_FILL);
      end
   end

   assign sym_ready      = r_sym_ready;
   assign dct_buffer     = r_buf;
   assign dct_count      = r_cnt;
   assign out_valid      = r_out_valid;
   assign out_word       = r_out_word;
   assign out_count      = r_out_count;
   assign test_has_ended = r_has_ended;
   assign drop_count     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_nios_with_no_onchip_sdram_cpu_oci_dct_ctrl.sv
// ============================================================================
// Module   : tb_nios_with_no_onchip_sdram_cpu_oci_dct_ctrl
// Purpose  : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_with_no_onchip_sdram_cpu_oci_dct_ctrl;

   localparam int IDLE = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sym_valid = 1'b0;
   logic [1:0]  sym_data = 2'd0;
   logic        test_ending = 1'b0;
   logic        out_ready = 1'b0;
   logic        sym_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        out_valid;
   logic [29:0] out_word;
   logic [3:0]  out_count;
   logic        test_has_ended;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_errors = 0;

   nios_with_no_onchip_sdram_cpu_oci_dct_ctrl #(.IDLE_FLUSH(IDLE)) dut (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
      .sym_ready(sym_ready), .test_ending(test_ending), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_count(out_count), .test_has_ended(test_has_ended),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Reference model: symbols held in a queue, mode 0=fill 1=flush 2=done.
   logic [1:0]  m_q[$];
   int          m_mode = 0;
   bit          m_ready = 0;
   logic [29:0] m_word = '0;
   int          m_wcount = 0;
   bit          m_end = 0;
   int          m_idle = 0;
   int          m_drop = 0;

   function automatic logic [29:0] m_pack();
      logic [29:0] w;
      w = '0;
      foreach (m_q[i]) w = w | (30'(m_q[i]) << (2 * i));
      return w;
   endfunction

   function automatic void model_step();
      bit acc;
      if (reset) begin
         m_q.delete(); m_mode = 0; m_ready = 0; m_word = '0; m_wcount = 0;
         m_end = 0; m_idle = 0; m_drop = 0;
         return;
      end
      if (sym_valid && !m_ready && m_drop < 255) m_drop++;
      if (m_mode == 0) begin
         acc = sym_valid && m_ready;
         if (acc) begin
            m_q.push_back(sym_data);
            m_idle = 0;
         end else if (m_q.size() > 0) m_idle = (m_idle < 255) ? m_idle + 1 : 255;
         else m_idle = 0;
         if (m_q.size() == 15 || (test_ending && m_q.size() > 0) ||
             (!acc && m_q.size() > 0 && m_idle == IDLE)) begin
            m_word = m_pack(); m_wcount = m_q.size();
            m_end = test_ending; m_mode = 1; m_idle = 0;
         end else if (test_ending) m_mode = 2;
      end else if (m_mode == 1) begin
         if (test_ending) m_end = 1;
         if (out_ready) begin
            m_q.delete();
            m_mode = m_end ? 2 : 0;
            m_end = 0;
         end
      end
      m_ready = (m_mode == 0);
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; sym_valid = 1'b0; test_ending = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; sym_valid = 1'b1; test_ending = 1'b0; out_ready = 1'b0;
      tick(); tick();
      n_checks++;
      if ({sym_ready, out_valid, test_has_ended} !== 3'b000) begin
         n_errors++; $display("FAIL reset_flags got %b want 000", {sym_ready, out_valid, test_has_ended});
      end
      n_checks++;
      if ({dct_buffer, dct_count, out_word, out_count, drop_count} !== '0) begin
         n_errors++; $display("FAIL reset_data buf=%h cnt=%0d word=%h oc=%0d drop=%0d want all 0",
                              dct_buffer, dct_count, out_word, out_count, drop_count);
      end
      reset = 1'b0; sym_valid = 1'b0;
      tick();
      n_checks++;
      if (sym_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_release_ready got %b want 1", sym_ready);
      end
   endtask

   task automatic test_full_fill();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         sym_valid = 1'b1; sym_data = 2'b01;
         tick();
      end
      sym_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== 30'h15555555 || out_count !== 4'd15) begin
         n_errors++; $display("FAIL full_word valid=%b word=%h count=%0d want 1 15555555 15",
                              out_valid, out_word, out_count);
      end
      n_checks++;
      if (sym_ready !== 1'b0) begin
         n_errors++; $display("FAIL full_ready got %b want 0", sym_ready);
      end
      tick();
      n_checks++;
      if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || out_valid !== 1'b0 || sym_ready !== 1'b1) begin
         n_errors++; $display("FAIL full_after cnt=%0d buf=%h valid=%b ready=%b want 0 0 0 1",
                              dct_count, dct_buffer, out_valid, sym_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [29:0] exp;
      logic [1:0]  s;
      do_reset();
      exp = '0;
      for (int i = 0; i < 15; i++) begin
         s = 2'($urandom_range(3));
         exp = exp | (30'(s) << (2 * i));
         sym_valid = 1'b1; sym_data = s;
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         sym_data = 2'($urandom_range(3));
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_word !== exp || out_count !== 4'd15) begin
            n_errors++; $display("FAIL bp_hold cyc=%0d valid=%b word=%h count=%0d want 1 %h 15",
                                 i, out_valid, out_word, out_count, exp);
         end
      end
      sym_valid = 1'b0;
      n_checks++;
      if (drop_count !== 8'd10) begin
         n_errors++; $display("FAIL bp_drop got %0d want 10", drop_count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_partial_end();
      logic [1:0] seq [3];
      seq = '{2'd3, 2'd2, 2'd1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         sym_valid = 1'b1; sym_data = seq[i];
         tick();
      end
      sym_valid = 1'b0; test_ending = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== 30'h1B || out_count !== 4'd3) begin
         n_errors++; $display("FAIL partial_word valid=%b word=%h count=%0d want 1 1b 3",
                              out_valid, out_word, out_count);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (test_has_ended !== 1'b1 || out_valid !== 1'b0 || sym_ready !== 1'b0) begin
         n_errors++; $display("FAIL partial_done ended=%b valid=%b ready=%b want 1 0 0",
                              test_has_ended, out_valid, sym_ready);
      end
      test_ending = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      int words;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         sym_valid = 1'b1; sym_data = 2'($urandom_range(3));
         tick();
      end
      test_ending = 1'b1;
      tick();
      sym_valid = 1'b0; test_ending = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 4'd15) begin
         n_errors++; $display("FAIL simul_word valid=%b count=%0d want 1 15", out_valid, out_count);
      end
      out_ready = 1'b1;
      words = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid === 1'b1) words++;
         tick();
      end
      n_checks++;
      if (words !== 1 || test_has_ended !== 1'b1) begin
         n_errors++; $display("FAIL simul_done words=%0d ended=%b want 1 1", words, test_has_ended);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_idle_flush();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         sym_valid = 1'b1; sym_data = 2'd2;
         tick();
      end
      sym_valid = 1'b0;
      for (int i = 0; i < IDLE - 1; i++) tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++; $display("FAIL idle_early valid=%b want 0", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 4'd2 || out_word !== 30'hA) begin
         n_errors++; $display("FAIL idle_word valid=%b count=%0d word=%h want 1 2 a",
                              out_valid, out_count, out_word);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (sym_ready !== 1'b1 || test_has_ended !== 1'b0 || dct_count !== 4'd0) begin
         n_errors++; $display("FAIL idle_back ready=%b ended=%b cnt=%0d want 1 0 0",
                              sym_ready, test_has_ended, dct_count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_flush();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         sym_valid = 1'b1; sym_data = 2'd3;
         tick();
      end
      sym_valid = 1'b0;
      reset = 1'b1;
      tick();
      n_checks++;
      if ({sym_ready, out_valid, test_has_ended, dct_buffer, dct_count, out_word, out_count, drop_count} !== '0) begin
         n_errors++; $display("FAIL rstflush_clear valid=%b word=%h cnt=%0d ready=%b want all 0",
                              out_valid, out_word, dct_count, sym_ready);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (sym_ready !== 1'b1) begin
         n_errors++; $display("FAIL rstflush_ready got %b want 1", sym_ready);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         sym_valid   = ($urandom_range(3) != 0);
         sym_data    = 2'($urandom_range(3));
         out_ready   = ($urandom_range(2) != 0);
         test_ending = ($urandom_range(150) == 0);
         reset       = (m_mode == 2 && $urandom_range(4) == 0) || ($urandom_range(400) == 0);
         tick();
         n_checks++;
         if (dct_buffer !== m_pack() || dct_count !== 4'(m_q.size())) begin
            n_errors++; $display("FAIL rand_buf cyc=%0d buf=%h cnt=%0d want %h %0d",
                                 c, dct_buffer, dct_count, m_pack(), m_q.size());
         end
         n_checks++;
         if (out_valid !== (m_mode == 1) || out_word !== m_word || out_count !== 4'(m_wcount)) begin
            n_errors++; $display("FAIL rand_out cyc=%0d valid=%b word=%h count=%0d want %b %h %0d",
                                 c, out_valid, out_word, out_count, (m_mode == 1), m_word, m_wcount);
         end
         n_checks++;
         if (sym_ready !== m_ready || test_has_ended !== (m_mode == 2)) begin
            n_errors++; $display("FAIL rand_ctrl cyc=%0d ready=%b ended=%b want %b %b",
                                 c, sym_ready, test_has_ended, m_ready, (m_mode == 2));
         end
         n_checks++;
         if (drop_count !== 8'(m_drop)) begin
            n_errors++; $display("FAIL rand_drop cyc=%0d got %0d want %0d", c, drop_count, m_drop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_fill();
      test_backpressure();
      test_partial_end();
      test_simultaneous();
      test_idle_flush();
      test_reset_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nios_with_no_onchip_sdram_cpu_oci_dct_ctrl.md
NIOS_WITH_NO_ONCHIP_SDRAM_CPU_OCI_DCT_CTRL -- requirements
Module: nios_with_no_onchip_sdram_cpu_oci_dct_ctrl

Interface
REQ-001 SHALL have parameter IDLE_FLUSH, default 64, which is the number of idle cycles (1..255) before a partial buffer is flushed; 0 disables the idle flush.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sym_valid, input, 1 bit: a trace symbol is offered.
REQ-005 SHALL have port sym_data, input, 2 bits: the trace symbol.
REQ-006 SHALL have port sym_ready, output, 1 bit: the symbol is accepted when sym_valid & sym_ready.
REQ-007 SHALL have port test_ending, input, 1 bit: a level request to flush and terminate capture.
REQ-008 SHALL have port dct_buffer, output, 30 bits: the packing buffer; symbol i is held at bits [2i+1:2i].
REQ-009 SHALL have port dct_count, output, 4 bits: the number of valid symbols in dct_buffer (0..15).
REQ-010 SHALL have port out_valid, output, 1 bit: a packed word is offered downstream.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the word when out_valid & out_ready.
REQ-012 SHALL have port out_word, output, 30 bits, and port out_count, output, 4 bits: the flushed buffer and its symbol count.
REQ-013 SHALL have port test_has_ended, output, 1 bit: capture terminated and the final word delivered.
REQ-014 SHALL have port drop_count, output, 8 bits: a saturating count of offered-but-refused symbols.

Function
REQ-015 SHALL implement the states FILL, FLUSH and DONE, with outputs registered.
REQ-016 SHALL, in FILL, drive sym_ready=1, write an accepted symbol to slot dct_count, and increment dct_count by 1.
REQ-017 SHALL, when a symbol is accepted with dct_count==14, set count to 15 and enter FLUSH on the next cycle with out_count=15.
REQ-018 SHALL, in FLUSH, drive sym_ready=0 and out_valid=1, and hold out_word/out_count stable until the handshake completes.
REQ-019 SHALL, on the out handshake, clear dct_buffer to 0 and dct_count to 0, then enter DONE if end_pending is set and FILL otherwise.
REQ-020 SHALL, when test_ending=1 in FILL with count>0 after any same-cycle accept, enter FLUSH with end_pending=1.
REQ-021 SHALL, when test_ending=1 in FILL with count==0 and no same-cycle accept, enter DONE directly without emitting a word.
REQ-022 SHALL, when sym_valid and test_ending arrive in the same FILL cycle, accept the symbol first and include it in the final word.
REQ-023 SHALL, when test_ending=1 during FLUSH, set end_pending; the current word completes, then the block enters DONE.
REQ-024 SHALL keep an 8-bit idle counter in FILL that clears on every accept and increments otherwise while count>0.
REQ-025 SHALL, when the idle counter reaches IDLE_FLUSH (≠0) with count>0, enter FLUSH with end_pending=0.
REQ-026 SHALL, in DONE, drive test_has_ended=1, sym_ready=0 and out_valid=0, and remain in DONE until reset.
REQ-027 SHALL increment drop_count whenever sym_valid=1 and sym_ready=0, saturating at 255.
REQ-028 SHALL ensure out_valid never deasserts without a handshake, except on reset.
REQ-029 SHALL hold buffer bits above slot count-1 at 0.

Reset
REQ-030 SHALL, while reset=1, force state=FILL, dct_buffer=0, dct_count=0, out_valid=0, out_word=0, out_count=0, test_has_ended=0, drop_count=0, end_pending=0, idle counter=0, and sym_ready=0.
REQ-031 SHALL, on reset asserted mid-FLUSH, discard the pending word with no handshake required.
REQ-032 SHALL drive sym_ready=1 from the first cycle after reset deasserts.

Verification
REQ-033 SHALL cover full fill: 15 symbols of 2'b01 with out_ready=1, giving out_word=30'h15555555, out_count=15, then count=0.
REQ-034 SHALL cover backpressure: a full buffer with out_ready=0 for 10 cycles while sym_valid=1, giving out_valid held, out_word stable and drop_count=10.
REQ-035 SHALL cover partial end: 3 symbols 3,2,1 then test_ending, giving out_word=30'h1B, out_count=3, then test_has_ended=1 one cycle after the handshake.
REQ-036 SHALL cover simultaneous events: test_ending with the 15th symbol in one cycle, giving a single word of count 15 followed by DONE.
REQ-037 SHALL cover idle flush: IDLE_FLUSH=4 and 2 symbols then idle, giving out_valid at the 4th idle cycle with out_count=2 and the block back in FILL.
REQ-038 SHALL cover reset during FLUSH: all outputs at their reset values next cycle and sym_ready=1 after release.
